// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two one-entry holding buffers (ALU result A, load result B)
// drained round-robin onto a single registered register-file write port.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              stall,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_sel
);

  logic              a_full_p0;
  logic              b_full_p0;
  logic [ADDR_W-1:0] a_addr_p0;
  logic [ADDR_W-1:0] b_addr_p0;
  logic [DATA_W-1:0] a_data_p0;
  logic [DATA_W-1:0] b_data_p0;
  logic              last_grant;  // 0 = A, 1 = B

  logic              grant_a;
  logic              grant_b;
  logic              acc_a;
  logic              acc_b;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grant depends only on buffer state, stall and flush, so ready never
  // depends on the requester's own valid.
  always_comb begin
    grant_a  = !stall && !flush && a_full_p0 && (!b_full_p0 || last_grant);
    grant_b  = !stall && !flush && b_full_p0 && (!a_full_p0 || !last_grant);
    a_ready  = !flush && (!a_full_p0 || grant_a);
    b_ready  = !flush && (!b_full_p0 || grant_b);
    acc_a    = a_valid && a_ready;
    acc_b    = b_valid && b_ready;
    gnt_addr = grant_b ? b_addr_p0 : a_addr_p0;
    gnt_data = grant_b ? b_data_p0 : a_data_p0;
  end

  // Stage p0: holding buffers. A refill on the drain edge keeps the buffer full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full_p0  <= 1'b0;
      b_full_p0  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      a_full_p0 <= acc_a || (a_full_p0 && !grant_a && !flush);
      b_full_p0 <= acc_b || (b_full_p0 && !grant_b && !flush);
      if (grant_a) begin
        last_grant <= 1'b0;
      end else if (grant_b) begin
        last_grant <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_a) begin
      a_addr_p0 <= a_addr;
      a_data_p0 <= a_data;
    end
    if (acc_b) begin
      b_addr_p0 <= b_addr;
      b_data_p0 <= b_data;
    end
  end

  // Stage p1: registered write port. Writes to register 0 are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_sel   <= 1'b0;
    end else begin
      rf_we <= (grant_a || grant_b) && (gnt_addr != '0);
      if (grant_a || grant_b) begin
        rf_waddr <= gnt_addr;
        rf_wdata <= gnt_data;
        wb_sel   <= grant_b;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              stall, flush;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_sel;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] qa[$];
  logic [ADDR_W+DATA_W-1:0] qb[$];

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic sel);
    chk({tag, ".we"},   64'(rf_we),    64'(we));
    chk({tag, ".addr"}, 64'(rf_waddr), 64'(addr));
    chk({tag, ".data"}, 64'(rf_wdata), 64'(data));
    chk({tag, ".sel"},  64'(wb_sel),   64'(sel));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic exp_sel;
    logic [ADDR_W+DATA_W-1:0] ent;
    int na, nb, nw;
    rst = 1'b1; a_valid = 0; b_valid = 0; a_addr = '0; b_addr = '0;
    a_data = '0; b_data = '0; stall = 0; flush = 0;

    // 1: reset state and single A write latency
    do_reset();
    chk_wr("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset.a_ready", 64'(a_ready), 64'd1);
    chk("reset.b_ready", 64'(b_ready), 64'd1);
    a_valid = 1; a_addr = 5'd5; a_data = 32'h11;
    #1 chk("t1.a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 0; a_addr = '0; a_data = '0;
    chk("t1.we_after_accept", 64'(rf_we), 64'd0);
    tick();
    chk_wr("t1.write", 1'b1, 5'd5, 32'h11, 1'b0);
    tick();
    chk("t1.we_drop", 64'(rf_we), 64'd0);

    // 2: simultaneous delivery, twice; A wins both times
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a_valid = 1; a_addr = 5'd3; a_data = 32'hA;
      b_valid = 1; b_addr = 5'd7; b_data = 32'hB;
      tick();
      a_valid = 0; b_valid = 0;
      tick();
      chk_wr("t2.first", 1'b1, 5'd3, 32'hA, 1'b0);
      tick();
      chk_wr("t2.second", 1'b1, 5'd7, 32'hB, 1'b1);
      tick();
      chk("t2.idle", 64'(rf_we), 64'd0);
    end

    // 3: continuous streams, strict alternation, scoreboard
    na = 0; nb = 0; nw = 0; exp_sel = 1'b0;
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a_addr = 5'(8 + na);  a_data = 32'h100 + 32'(na);
      b_addr = 5'(16 + nb); b_data = 32'h200 + 32'(nb);
      #1;
      if (a_ready) begin qa.push_back({a_addr, a_data}); na++; end
      if (b_ready) begin qb.push_back({b_addr, b_data}); nb++; end
      tick();
      if (i > 0) begin
        chk("t3.we", 64'(rf_we), 64'd1);
        chk("t3.sel", 64'(wb_sel), 64'(exp_sel));
        if (exp_sel) ent = (qb.size() > 0) ? qb.pop_front() : '1;
        else         ent = (qa.size() > 0) ? qa.pop_front() : '1;
        chk("t3.word", 64'({rf_waddr, rf_wdata}), 64'(ent));
        exp_sel = ~exp_sel;
        nw++;
      end
    end
    a_valid = 0; b_valid = 0;
    for (int i = 0; i < 4 && (qa.size() + qb.size()) > 0; i++) begin
      tick();
      chk("t3.drain_sel", 64'(wb_sel), 64'(exp_sel));
      if (exp_sel) ent = (qb.size() > 0) ? qb.pop_front() : '1;
      else         ent = (qa.size() > 0) ? qa.pop_front() : '1;
      chk("t3.drain_word", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, ent}));
      exp_sel = ~exp_sel;
      nw++;
    end
    chk("t3.writes", 64'(nw), 64'd9);
    chk("t3.left", 64'(qa.size() + qb.size()), 64'd0);
    tick();
    chk("t3.idle", 64'(rf_we), 64'd0);

    // 4: write to register 0 is consumed silently
    b_valid = 1; b_addr = 5'd0; b_data = 32'hFF;
    #1 chk("t4.b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 0;
    tick();
    chk_wr("t4.zero", 1'b0, 5'd0, 32'hFF, 1'b1);
    chk("t4.b_ready_back", 64'(b_ready), 64'd1);

    // 5: stall with both buffers full
    a_valid = 1; a_addr = 5'd9;  a_data = 32'h99;
    b_valid = 1; b_addr = 5'd10; b_data = 32'hAA;
    tick();
    a_valid = 0; b_valid = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5.a_ready", 64'(a_ready), 64'd0);
      chk("t5.b_ready", 64'(b_ready), 64'd0);
      tick();
      chk("t5.we", 64'(rf_we), 64'd0);
    end
    stall = 0;
    tick();
    chk_wr("t5.first", 1'b1, 5'd9, 32'h99, 1'b0);
    tick();
    chk_wr("t5.second", 1'b1, 5'd10, 32'hAA, 1'b1);
    tick();
    chk("t5.idle", 64'(rf_we), 64'd0);

    // 6: flush discards both buffers and blocks the concurrent A offer
    a_valid = 1; a_addr = 5'd11; a_data = 32'h1;
    b_valid = 1; b_addr = 5'd12; b_data = 32'h2;
    tick();
    b_valid = 0; flush = 1; a_addr = 5'd13; a_data = 32'h3;
    #1;
    chk("t6.a_ready_flush", 64'(a_ready), 64'd0);
    chk("t6.b_ready_flush", 64'(b_ready), 64'd0);
    tick();
    flush = 0; a_valid = 0;
    chk("t6.we_flush", 64'(rf_we), 64'd0);
    tick();
    chk("t6.we_after", 64'(rf_we), 64'd0);
    tick();
    chk("t6.we_after2", 64'(rf_we), 64'd0);
    a_valid = 1; a_addr = 5'd14; a_data = 32'h4;
    tick();
    a_valid = 0;
    tick();
    chk_wr("t6.next", 1'b1, 5'd14, 32'h4, 1'b0);
    tick();
    chk("t6.only", 64'(rf_we), 64'd0);

    // asynchronous reset mid-stream
    a_valid = 1; a_addr = 5'd15; a_data = 32'h5;
    tick();
    a_valid = 1; a_addr = 5'd17; a_data = 32'h6;
    tick();
    a_valid = 0;
    chk_wr("rst.pre", 1'b1, 5'd15, 32'h5, 1'b0);
    #1 rst = 1'b1;
    #1 chk_wr("rst.async", 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst.lost", 64'(rf_we), 64'd0);
    chk("rst.a_ready", 64'(a_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
